// File: rtl/oam_dma.sv
// Sprite DMA initiator: snoops CPU writes to DMA_REG_ADDR, halts the CPU and copies XFER_LEN bytes
// from page {page,00} into the OAM data port. Optional odd-cycle alignment via ODD_CYCLE_ALIGN_EN.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_en,
  output logic [15:0] dma_addr_out,
  output logic [7:0]  dma_data_out,
  output logic        dma_read_en,
  output logic        dma_write_en,
  input  logic [7:0]  mem_data_in,
  input  logic        mem_busy,
  output logic        cpu_halt,
  output logic        dma_active,
  output logic        dma_done
);

  localparam int unsigned IW = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_page;
  logic [7:0]      w_page_next;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_next;
  logic            w_trigger;
  logic [7:0]      w_src_lo;

  assign w_trigger = cpu_write_en && (cpu_addr_in == DMA_REG_ADDR);
  assign w_src_lo  = 8'(r_idx);

`ifdef ODD_CYCLE_ALIGN_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_parity <= 1'b0;
    else      r_parity <= ~r_parity;
  end
`endif

  // mem_busy freezes the whole engine, so every output (decoded from state) is held too
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_page  <= '0;
      r_idx   <= '0;
    end else if (!mem_busy) begin
      r_state <= w_next;
      r_page  <= w_page_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_page_next  = r_page;
    w_idx_next   = r_idx;
    dma_addr_out = '0;
    dma_data_out = '0;
    dma_read_en  = 1'b0;
    dma_write_en = 1'b0;
    cpu_halt     = 1'b0;
    dma_active   = 1'b0;
    dma_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_page_next = cpu_data_in;
          w_idx_next  = '0;
          w_next      = S_HALT;
        end
      end
      S_HALT: begin
        cpu_halt   = 1'b1;
        dma_active = 1'b1;
`ifdef ODD_CYCLE_ALIGN_EN
        w_next     = r_parity ? S_ALIGN : S_READ;
`else
        w_next     = S_READ;
`endif
      end
      S_ALIGN: begin
        cpu_halt   = 1'b1;
        dma_active = 1'b1;
        w_next     = S_READ;
      end
      S_READ: begin
        cpu_halt     = 1'b1;
        dma_active   = 1'b1;
        dma_read_en  = 1'b1;
        dma_addr_out = {r_page, w_src_lo};
        w_next       = S_WRITE;
      end
      S_WRITE: begin
        cpu_halt     = 1'b1;
        dma_active   = 1'b1;
        dma_write_en = 1'b1;
        dma_addr_out = OAM_DATA_ADDR;
        dma_data_out = mem_data_in;
        if (r_idx == LAST_IDX) begin
          w_next = S_DONE;
        end else begin
          w_idx_next = r_idx + IW'(1);
          w_next     = S_READ;
        end
      end
      S_DONE: begin
        dma_done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a queue of expected bus cycles per transfer, a memory model
// standing in for mem_ctrl/CPU RAM/sprite RAM, and randomized CPU noise and mem_busy stalls.
module tb_oam_dma;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        cpu_write_en;
  logic [15:0] dma_addr_out;
  logic [7:0]  dma_data_out;
  logic        dma_read_en;
  logic        dma_write_en;
  logic [7:0]  mem_data_in;
  logic        mem_busy;
  logic        cpu_halt;
  logic        dma_active;
  logic        dma_done;

  oam_dma #(
    .DMA_REG_ADDR (16'h4014),
    .OAM_DATA_ADDR(16'h2004),
    .XFER_LEN     (256)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr_in  (cpu_addr_in),
    .cpu_data_in  (cpu_data_in),
    .cpu_write_en (cpu_write_en),
    .dma_addr_out (dma_addr_out),
    .dma_data_out (dma_data_out),
    .dma_read_en  (dma_read_en),
    .dma_write_en (dma_write_en),
    .mem_data_in  (mem_data_in),
    .mem_busy     (mem_busy),
    .cpu_halt     (cpu_halt),
    .dma_active   (dma_active),
    .dma_done     (dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- memory model (CPU RAM, mem_ctrl read latency, sprite RAM) ----------------
  logic [7:0] ram [65536];
  logic [7:0] oam [256];
  int         wcnt [256];
  logic [7:0] oam_ptr;
  logic [7:0] rdata;
  assign mem_data_in = rdata;

  always @(posedge clk) begin
    if (dma_read_en) rdata <= ram[dma_addr_out];
    if (dma_write_en && !mem_busy && dma_addr_out == 16'h2004) begin
      oam[oam_ptr]  <= dma_data_out;
      wcnt[oam_ptr] <= wcnt[oam_ptr] + 1;
      oam_ptr       <= oam_ptr + 8'd1;
    end
  end

  // ---------------- reference model: queue of expected bus cycles ----------------
  typedef struct packed {
    logic        halt;
    logic        act;
    logic        rd;
    logic        wr;
    logic        done;
    logic        is_halt;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        q[$];
  exp_t        popped;
  exp_t        cur;
  int unsigned edge_cnt;
  int          align_cnt = 0;
  logic        was_empty;

  task automatic build(input logic [7:0] page);
    exp_t e;
    e = '0; e.halt = 1; e.act = 1; e.is_halt = 1;
    q.push_back(e);
    for (int i = 0; i < 256; i++) begin
      e = '0; e.halt = 1; e.act = 1; e.rd = 1; e.addr = {page, 8'(i)};
      q.push_back(e);
      e = '0; e.halt = 1; e.act = 1; e.wr = 1; e.addr = 16'h2004; e.data = ram[{page, 8'(i)}];
      q.push_back(e);
    end
    e = '0; e.done = 1;
    q.push_back(e);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      edge_cnt = 0;
    end else begin
      was_empty = (q.size() == 0);
      if (!mem_busy) begin
        if (!was_empty) begin
          popped = q.pop_front();
`ifdef ODD_CYCLE_ALIGN_EN
          if (popped.is_halt && edge_cnt[0]) begin
            exp_t a;
            a = '0; a.halt = 1; a.act = 1;
            q.push_front(a);
            align_cnt++;
          end
`endif
        end else if (cpu_write_en && cpu_addr_in == 16'h4014) begin
          build(cpu_data_in);
        end
      end
      edge_cnt++;
    end
  end

  // ---------------- per-cycle compare + statistics ----------------
  int          halt_cnt;
  int          done_cnt;
  int          hold_cnt;
  logic [15:0] rd_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", {cpu_halt, dma_active, dma_read_en, dma_write_en, dma_done,
                            dma_addr_out, dma_data_out}, 32'h0);
    end else begin
      cur = (q.size() != 0) ? q[0] : '0;
      chk("ctrl{halt,act,rd,wr,done}", {27'h0, cpu_halt, dma_active, dma_read_en, dma_write_en, dma_done},
          {27'h0, cur.halt, cur.act, cur.rd, cur.wr, cur.done});
      if (cur.rd || cur.wr) chk("bus_addr", {16'h0, dma_addr_out}, {16'h0, cur.addr});
      if (cur.wr)           chk("bus_data", {24'h0, dma_data_out}, {24'h0, cur.data});
      if (cpu_halt) halt_cnt++;
      if (dma_done) done_cnt++;
      if (dma_read_en) begin
        if (rd_log.size() == 0 || rd_log[$] != dma_addr_out || !cur.rd) rd_log.push_back(dma_addr_out);
        if (dma_addr_out == 16'h0240) hold_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_stats();
    @(negedge clk);
    halt_cnt = 0; done_cnt = 0; hold_cnt = 0;
    rd_log.delete();
    for (int i = 0; i < 256; i++) begin oam[i] = 8'h00; wcnt[i] = 0; end
    oam_ptr = 8'h00;
  endtask

  task automatic idle_noise(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cpu_write_en = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       cpu_addr_in = 16'h4015;
        1:       cpu_addr_in = 16'h2004;
        default: cpu_addr_in = 16'($urandom);
      endcase
      if (cpu_addr_in == 16'h4014) cpu_addr_in = 16'h4013;
      cpu_data_in = 8'($urandom);
    end
    @(posedge clk); #1;
    cpu_write_en = 1'b0;
  endtask

  task automatic trigger(input logic [7:0] page);
    @(posedge clk); #1;
    cpu_addr_in = 16'h4014; cpu_data_in = page; cpu_write_en = 1'b1;
    @(posedge clk); #1;
    cpu_write_en = 1'b0; cpu_addr_in = 16'h0000;
  endtask

  task automatic wait_done(input int budget, input bit rand_busy);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      if (rand_busy) mem_busy = ($urandom_range(0, 3) == 0);
      @(negedge clk); #1;
      n++;
    end
    mem_busy = 1'b0;
    chk("done_within_budget", {31'h0, done_cnt != 0}, 32'h1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_rd(input logic [15:0] a, input int budget);
    int  n;
    bit  found;
    n = 0; found = 0;
    while (!found && n < budget) begin
      @(negedge clk); #1;
      if (dma_read_en && dma_addr_out == a) found = 1;
      n++;
    end
    chk("read_addr_reached", {31'h0, found}, 32'h1);
  endtask

  task automatic check_copy(input logic [7:0] page, input string tag);
    chk({tag, "_nreads"}, rd_log.size(), 256);
    for (int i = 0; i < 256; i++) begin
      if (i < rd_log.size()) chk({tag, "_rd_addr"}, {16'h0, rd_log[i]}, {16'h0, page, 8'(i)});
      chk({tag, "_oam"}, {24'h0, oam[i]}, {24'h0, ram[{page, 8'(i)}]});
      chk({tag, "_wcnt"}, wcnt[i], 1);
    end
  endtask

  int a0;
  int h1;
  int h2;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_busy = 1'b0;
    cpu_addr_in = 16'h4014; cpu_data_in = 8'h05; cpu_write_en = 1'b1;
    for (int a = 0; a < 65536; a++) ram[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 256; i++) ram[16'h0700 + i] = 8'(i * 3 + 1);

    // reset with a $4014 write pending; it must not start anything
    repeat (10) @(posedge clk);
    @(negedge clk);
    cpu_write_en = 1'b0; cpu_addr_in = 16'h0000;
    rst = 1'b1;
    clear_stats();
    repeat (3) @(negedge clk);
    #1;
    chk("post_reset_all_zero", {cpu_halt, dma_active, dma_read_en, dma_write_en, dma_done,
                                dma_addr_out, dma_data_out}, 32'h0);
    chk("post_reset_no_halt", halt_cnt, 0);
    idle_noise(8);

    // full copy of page $02
    clear_stats();
    a0 = align_cnt;
    trigger(8'h02);
    wait_done(2000, 1'b0);
    chk("copy_halt_cycles", halt_cnt, 513 + (align_cnt - a0));
    chk("copy_done_pulses", done_cnt, 1);
    for (int i = 0; i < 256; i++) chk("copy_oam_literal", {24'h0, oam[i]}, {24'h0, 8'(i) ^ 8'hA5});
    check_copy(8'h02, "copy");

    // busy stall on idx $40
    idle_noise(3);
    clear_stats();
    a0 = align_cnt;
    trigger(8'h02);
    wait_rd(16'h0240, 1000);
    mem_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_busy = 1'b0;
    wait_done(2000, 1'b0);
    chk("busy_hold_cycles", hold_cnt, 4);
    chk("busy_halt_cycles", halt_cnt, 516 + (align_cnt - a0));
    chk("busy_byte40_writes", wcnt[8'h40], 1);
    chk("busy_byte40_data", {24'h0, oam[8'h40]}, {24'h0, 8'h40 ^ 8'hA5});

    // retrigger mid-transfer is ignored
    idle_noise(4);
    clear_stats();
    trigger(8'h02);
    repeat (100) @(negedge clk);
    trigger(8'h03);
    wait_done(2000, 1'b0);
    chk("retrig_done_pulses", done_cnt, 1);
    check_copy(8'h02, "retrig");

    // abort by reset at idx $80, then a clean transfer of page $07
    clear_stats();
    trigger(8'h02);
    wait_rd(16'h0280, 1000);
    rst = 1'b0;
    #1;
    chk("abort_outputs_zero", {cpu_halt, dma_active, dma_read_en, dma_write_en, dma_done,
                               dma_addr_out, dma_data_out}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_released", {31'h0, cpu_halt}, 32'h0);
    clear_stats();
    trigger(8'h07);
    wait_done(2000, 1'b0);
    chk("post_abort_first_read", {16'h0, rd_log[0]}, 32'h0700);
    chk("post_abort_done", done_cnt, 1);
    check_copy(8'h07, "post_abort");

    // random page with random mem_busy stalls, model carries the timing
    for (int t = 0; t < 2; t++) begin
      logic [7:0] pg;
      pg = 8'($urandom);
      if (pg == 8'h02) pg = 8'h11;
      idle_noise(int'($urandom_range(1, 6)));
      clear_stats();
      trigger(pg);
      wait_done(4000, 1'b1);
      check_copy(pg, "rand_busy");
    end

    // page $FF must end at $FFFF with no carry into the page byte
    clear_stats();
    a0 = align_cnt;
    trigger(8'hFF);
    wait_done(2000, 1'b0);
    h1 = halt_cnt;
    chk("pageff_last_read", {16'h0, rd_log[$]}, 32'h0000FFFF);
    chk("pageff_halt_cycles", h1, 513 + (align_cnt - a0));
`ifdef ODD_CYCLE_ALIGN_EN
    clear_stats();
    @(negedge clk);
    trigger(8'hFF);
    wait_done(2000, 1'b0);
    h2 = halt_cnt;
    chk("align_sum_513_514", h1 + h2, 1027);
    chk("align_distinct", {31'h0, h1 != h2}, 32'h1);
`else
    h2 = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
